// File: rtl/div32_seq.sv
// ============================================================================
// Module   : div32_seq
// Brief    : Sequential radix-2 restoring divider. It produces one quotient bit
//            per clock and has fixed latency. Divide-by-zero is reported
//            separately.
//            Optional macro DIV32_SEQ_SIGNED_EN enables two's-complement signed
//            division, which runs the core on operand magnitudes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             c_CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(WIDTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_rem;       // partial remainder
  logic [WIDTH-1:0]   r_quo;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   r_dvsr;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_dbz;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH+1:0]   w_trial;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_q_fin;
  logic [WIDTH-1:0]   w_r_fin;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor
  always_comb begin
    w_shift    = {r_rem, r_quo[WIDTH-1]};
    w_trial    = {1'b0, w_shift} - {2'b00, r_dvsr};
    w_borrow   = w_trial[WIDTH+1];
    w_rem_next = w_borrow ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_quo_next = {r_quo[WIDTH-2:0], ~w_borrow};
  end

`ifdef DIV32_SEQ_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  // Signed operands enter the core as magnitudes; signs are restored at the end
  always_comb begin
    w_a_mag = dividend[WIDTH-1] ? ({WIDTH{1'b0}} - dividend) : dividend;
    w_b_mag = divisor[WIDTH-1]  ? ({WIDTH{1'b0}} - divisor)  : divisor;
    w_q_fin = r_neg_q ? ({WIDTH{1'b0}} - w_quo_next) : w_quo_next;
    w_r_fin = r_neg_r ? ({WIDTH{1'b0}} - w_rem_next) : w_rem_next;
  end

  // Remember result signs: quotient negative when signs differ, remainder follows dividend
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == c_IDLE && start) begin
      r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_r <= dividend[WIDTH-1];
    end
  end
`else
  // Unsigned build: operands and results pass straight through
  always_comb begin
    w_a_mag = dividend;
    w_b_mag = divisor;
    w_q_fin = w_quo_next;
    w_r_fin = w_rem_next;
  end
`endif

  // Control FSM, iteration datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_rem  <= '0;
            r_cnt  <= '0;
            r_quo  <= w_a_mag;
            r_dvsr <= w_b_mag;
            if (divisor == '0) begin
              // Zero divisor skips the iterations; results are known immediately
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
              r_state     <= c_DONE;
            end else begin
              r_state <= c_RUN;
            end
          end
        end
        c_RUN: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST_CNT) begin
            // Final step: publish results so they are valid in the done cycle
            r_quotient  <= w_q_fin;
            r_remainder <= w_r_fin;
            r_dbz       <= 1'b0;
            r_state     <= c_DONE;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign busy        = (r_state != c_IDLE);
  assign done        = (r_state == c_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_div32_seq.sv
// ============================================================================
// Module   : tb_div32_seq
// Brief    : Directed self-checking bench for div32_seq with hand-computed
//            expected values. Builds with or without DIV32_SEQ_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div32_seq;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int n_checks;
  int n_errors;
  int cyc;

  div32_seq #(.WIDTH(WIDTH)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used to measure latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for done, bounded; returns latency counted from the start edge
  task automatic wait_done(input int c0, output int lat);
    while (done !== 1'b1 && (cyc - c0) < 60) begin
      @(posedge clk);
      #1;
    end
    lat = cyc - c0 + 1;
  endtask

  // Issue one division (caller sits just after an edge) and check everything
  task automatic do_div(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                        input logic edbz, input int elat);
    int c0;
    int lat;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
    check({tag, " busy"}, {63'd0, busy}, 64'd1);
    wait_done(c0, lat);
    check({tag, " lat"}, 64'(lat), 64'(elat));
    check({tag, " q"}, {32'd0, quotient}, {32'd0, eq});
    check({tag, " r"}, {32'd0, remainder}, {32'd0, er});
    check({tag, " dbz"}, {63'd0, div_by_zero}, {63'd0, edbz});
    @(posedge clk);
    #1;
    check({tag, " pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int c0;
    int lat;
    int seen;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst outs", {quotient, remainder}, 64'd0);
    check("rst flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    rst = 1'b0;

    // Basic and boundary vectors
    do_div("basic", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
`ifdef DIV32_SEQ_SIGNED_EN
    do_div("s neg", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    do_div("s min", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    do_div("s pos", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 33);
`else
    do_div("max", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    do_div("small", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33);
    do_div("big", 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 33);
`endif
    do_div("zero", 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1);

    // Results hold while operand inputs wander
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    check("hold", {quotient, remainder}, {32'hFFFF_FFFF, 32'h1234});
    check("hold dbz", {63'd0, div_by_zero}, 64'd1);

    // Start while busy is ignored, including in the done cycle
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(c0, lat);
    check("busy lat", 64'(lat), 64'd33);
    check("busy res", {quotient, remainder}, {32'd14, 32'd2});
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done-start idle", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    check("done-start ign", {63'd0, busy}, 64'd0);
    do_div("after", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);

    // Asynchronous reset in the middle of an operation
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
    while ((cyc - c0) < 14) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check("arst outs", {quotient, remainder}, 64'd0);
    check("arst flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    check("abort nodone", 64'(seen), 64'd0);
    do_div("post rst", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
